// File: rtl/forwarding_scoreboard.sv
// Dest-register scoreboard for stages after ID: bypass selects and load-use stall, combinational (zero latency).
// stall_in freezes every entry and the stall counter; a load-use stall or a flush turns the ID slot into a bubble.
module forwarding_scoreboard #(
    parameter int REG_BITS = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      stall_in,
    input  logic                                      flush,
    input  logic                                      issue_valid,
    input  logic [REG_BITS-1:0]                       issue_dest,
    input  logic                                      issue_wb,
    input  logic                                      issue_is_load,
    input  logic [NUM_SRC*REG_BITS-1:0]               src_addr,
    input  logic [NUM_SRC-1:0]                        src_used,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]        sel_out,
    output logic                                      hazard_stall,
    output logic [DEPTH-1:0]                          stage_valid,
    output logic [15:0]                               stall_count
);

    localparam int SEL_BITS = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                vld;
        logic [REG_BITS-1:0] dest;
        logic                wb;
        logic                is_load;
    } entry_t;

    entry_t               ent [1:DEPTH];
    logic   [NUM_SRC-1:0] hit;
    entry_t               new_ent;

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            stage_valid[k-1] = ent[k].vld;
        end
    end

    // Scan from EX outward so the youngest producer claims the operand first.
    always_comb begin
        sel_out      = '0;
        hazard_stall = 1'b0;
        hit          = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!hit[i] && src_used[i] && ent[k].vld && ent[k].wb &&
                    (ent[k].dest == src_addr[i*REG_BITS +: REG_BITS]) &&
                    (ent[k].dest != '0)) begin
                    hit[i] = 1'b1;
                    sel_out[i*SEL_BITS +: SEL_BITS] = SEL_BITS'(k);
                    if (ent[k].is_load && (k < LOAD_LAT)) begin
                        hazard_stall = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        new_ent.vld     = issue_valid & ~hazard_stall & ~flush;
        new_ent.dest    = issue_dest;
        new_ent.wb      = issue_wb;
        new_ent.is_load = issue_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent[k] <= '0;
            end
            stall_count <= '0;
        end else if (!stall_in) begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent[k] <= ent[k-1];
            end
            ent[1] <= new_ent;
            if (hazard_stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed checks on a default scoreboard plus a deep-load instance that drives the stall counter to saturation.
module tb_forwarding_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        stall_in, flush, issue_valid, issue_wb, issue_is_load;
    logic [4:0]  issue_dest;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic [3:0]  sel_out;
    logic        hazard_stall;
    logic [2:0]  stage_valid;
    logic [15:0] stall_count;

    logic [7:0]  sel_out_b;
    logic        hazard_stall_b;
    logic [14:0] stage_valid_b;
    logic [15:0] stall_count_b;

    int total = 0;
    int bad   = 0;

    forwarding_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_wb(issue_wb),
        .issue_is_load(issue_is_load), .src_addr(src_addr), .src_used(src_used),
        .sel_out(sel_out), .hazard_stall(hazard_stall), .stage_valid(stage_valid),
        .stall_count(stall_count)
    );

    // Every cycle issues "LW r3" that also reads r3: 14 stalls per 15 cycles.
    forwarding_scoreboard #(.DEPTH(15), .LOAD_LAT(15)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_in(1'b0), .flush(1'b0),
        .issue_valid(1'b1), .issue_dest(5'd3), .issue_wb(1'b1),
        .issue_is_load(1'b1), .src_addr({5'd0, 5'd3}), .src_used(2'b01),
        .sel_out(sel_out_b), .hazard_stall(hazard_stall_b), .stage_valid(stage_valid_b),
        .stall_count(stall_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic wb, input logic ld,
                         input logic [4:0] s0, input logic u0, input logic [4:0] s1, input logic u1);
        issue_valid   = v;
        issue_dest    = d;
        issue_wb      = wb;
        issue_is_load = ld;
        src_addr      = {s1, s0};
        src_used      = {u1, u0};
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        stall_in = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("rst_valid", stage_valid, 3'b000);
        chk("rst_count", stall_count, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Two r5 producers, then consumers at distance 1 and 2.
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        chk("fwd_ex", sel_out[1:0], 2'd1);
        chk("fwd_ex_hz", hazard_stall, 1'b0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        chk("fwd_mem", sel_out[1:0], 2'd2);
        chk("full_valid", stage_valid, 3'b111);

        // Asynchronous reset in mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", stage_valid, 3'b000);
        chk("arst_sel", sel_out, 4'd0);
        chk("arst_hz", hazard_stall, 1'b0);
        chk("arst_count", stall_count, 16'd0);
        idle(0);
        rst_n = 1'b1;
        tick();

        // r0 is never forwarded; an unused operand never selects.
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        chk("r0_sel", sel_out[1:0], 2'd0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b0);
        chk("unused_sel1", sel_out[3:2], 2'd0);
        chk("used_sel0", sel_out[1:0], 2'd1);
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        chk("used_sel1", sel_out[3:2], 2'd1);

        // Load-use costs one bubble.
        idle(3);
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("lu_hz", hazard_stall, 1'b1);
        chk("lu_sel_young", sel_out[1:0], 2'd1);
        tick();
        chk("lu_hz_clear", hazard_stall, 1'b0);
        chk("lu_sel_mem", sel_out[1:0], 2'd2);
        chk("lu_bubble", stage_valid, 3'b010);
        chk("lu_count", stall_count, 16'd1);
        tick();
        chk("lu_after", stage_valid, 3'b101);
        chk("lu_count_hold", stall_count, 16'd1);

        // Younger ALU write shadows the older load.
        idle(3);
        drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        chk("shadow_sel", sel_out[1:0], 2'd1);
        chk("shadow_hz", hazard_stall, 1'b0);

        // Freeze for three cycles.
        stall_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("frz_valid", stage_valid, 3'b011);
            chk("frz_sel", sel_out[1:0], 2'd1);
            chk("frz_count", stall_count, 16'd1);
        end
        stall_in = 1'b0;

        // Flush turns a real instruction into a bubble.
        flush = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0); tick();
        chk("flush_valid", stage_valid, 3'b110);

        // Flush during a load-use stall: one bubble, counter still moves.
        flush = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        chk("fl_load_in", stage_valid, 3'b101);
        flush = 1'b1;
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        chk("fl_hz", hazard_stall, 1'b1);
        tick();
        flush = 1'b0;
        chk("fl_count", stall_count, 16'd2);
        chk("fl_valid", stage_valid, 3'b010);

        // Hazard under freeze does not count.
        drive(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        stall_in = 1'b1;
        drive(1'b1, 5'd14, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
        chk("fz_hz", hazard_stall, 1'b1);
        tick(); tick();
        chk("fz_hz_hold", hazard_stall, 1'b1);
        chk("fz_count", stall_count, 16'd2);
        stall_in = 1'b0;
        tick();
        chk("fz_count_go", stall_count, 16'd3);
        chk("fz_hz_done", hazard_stall, 1'b0);
        idle(1);

        // Saturation on the deep instance.
        cyc = 0;
        while (stall_count_b != 16'hFFFF && cyc < 80000) begin
            tick();
            cyc++;
        end
        chk("sat_reach", stall_count_b, 16'hFFFF);
        for (int j = 0; j < 40; j++) tick();
        chk("sat_hold", stall_count_b, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
